// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: register map, FSM states and word types shared by
// the PLL reconfiguration writer and its bench.
package pll_cfg_pkg;

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_START = 6'h02;
  localparam logic [5:0] ADDR_N     = 6'h03;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;

  typedef logic [17:0] cnt_word_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_N,
    ST_WR_M,
    ST_WR_K,
    ST_WR_C,
    ST_RD_N,
    ST_RD_M,
    ST_RD_K,
    ST_WR_START,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic [31:0] cnt_data(cnt_word_t w);
    return {14'b0, w};
  endfunction

endpackage

// File: rtl/pll_reconfig_writer_lock_sync.sv
// pll_lock_sync: SYNC_STAGES-deep flop chain bringing the raw
// pll_locked level into the management clock domain.
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reconfig_writer.sv
// pll_reconfig_writer: programs N/M/K/C over Avalon-MM, then waits for lock.
// Define PLL_RECFG_READBACK_EN to verify N/M/K by readback before START.
module pll_reconfig_writer
  import pll_cfg_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int LOCK_STABLE  = 256,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [17:0] n_val,
  input  logic [17:0] m_val,
  input  logic [31:0] k_val,
  input  logic [4:0]  c_sel,
  input  logic [17:0] c_val,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(LOCK_TIMEOUT);
  localparam logic [SW-1:0] STB_MAX = SW'(LOCK_STABLE);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  cnt_word_t   n_q, n_d;
  cnt_word_t   m_q, m_d;
  cnt_word_t   c_q, c_d;
  logic [31:0] k_q, k_d;
  logic [4:0]  csel_q, csel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] stb_q, stb_d;
  logic        lock_s;
  logic        go_err;

  pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pll_locked),
    .sync_o  (lock_s)
  );

`ifndef PLL_RECFG_READBACK_EN
  logic unused_rdata;
  assign unused_rdata = ^mgmt_readdata;
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    n_d     = n_q;
    m_d     = m_q;
    c_d     = c_q;
    k_d     = k_q;
    csel_d  = csel_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    go_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (req) begin
        n_d     = n_val;
        m_d     = m_val;
        k_d     = k_val;
        csel_d  = c_sel;
        c_d     = c_val;
        state_d = ST_WR_MODE;
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = ADDR_MODE;
        wdata_d = '0;
      end
      ST_WR_MODE: if (!mgmt_waitrequest) begin
        state_d = ST_WR_N;
        addr_d  = ADDR_N;
        wdata_d = cnt_data(n_q);
      end
      ST_WR_N: if (!mgmt_waitrequest) begin
        state_d = ST_WR_M;
        addr_d  = ADDR_M;
        wdata_d = cnt_data(m_q);
      end
      ST_WR_M: if (!mgmt_waitrequest) begin
        state_d = ST_WR_K;
        addr_d  = ADDR_K;
        wdata_d = k_q;
      end
      ST_WR_K: if (!mgmt_waitrequest) begin
        state_d = ST_WR_C;
        addr_d  = ADDR_C;
        wdata_d = {9'b0, csel_q, c_q};
      end
      ST_WR_C: if (!mgmt_waitrequest) begin
`ifdef PLL_RECFG_READBACK_EN
        state_d = ST_RD_N;
        wr_d    = 1'b0;
        rd_d    = 1'b1;
        addr_d  = ADDR_N;
        wdata_d = '0;
`else
        state_d = ST_WR_START;
        addr_d  = ADDR_START;
        wdata_d = 32'd1;
`endif
      end
`ifdef PLL_RECFG_READBACK_EN
      ST_RD_N: if (!mgmt_waitrequest) begin
        if (mgmt_readdata[17:0] != n_q) go_err = 1'b1;
        else begin
          state_d = ST_RD_M;
          addr_d  = ADDR_M;
        end
      end
      ST_RD_M: if (!mgmt_waitrequest) begin
        if (mgmt_readdata[17:0] != m_q) go_err = 1'b1;
        else begin
          state_d = ST_RD_K;
          addr_d  = ADDR_K;
        end
      end
      ST_RD_K: if (!mgmt_waitrequest) begin
        if (mgmt_readdata != k_q) go_err = 1'b1;
        else begin
          state_d = ST_WR_START;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          addr_d  = ADDR_START;
          wdata_d = 32'd1;
        end
      end
`endif
      ST_WR_START: if (!mgmt_waitrequest) begin
        state_d = ST_WAIT_LOCK;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        tmo_d   = '0;
        stb_d   = '0;
      end
      // Stable is tested before timeout so a tie resolves to DONE.
      ST_WAIT_LOCK: begin
        if (stb_q == STB_MAX) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tmo_q == TMO_MAX) begin
          go_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
          stb_d = lock_s ? stb_q + SW'(1) : '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (go_err) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      m_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      csel_q  <= '0;
      tmo_q   <= '0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c_q     <= c_d;
      k_q     <= k_d;
      csel_q  <= csel_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mgmt_write     = wr_q;
  assign mgmt_read      = rd_q;
  assign mgmt_address   = addr_q;
  assign mgmt_writedata = wdata_q;

endmodule
